// File: rtl/madd.sv
// 32-bit signed multiply-add Z = (rA*rB + C) mod 2^32. A/B are registered and C is added
// combinationally. Radix-4 Booth rows and C reduce through a 3:2 CSA tree into one final adder.
module madd (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [31:0] C,
    output logic [31:0] Z
);

    localparam int N_PP     = 16;
    localparam int N_ROWS   = N_PP + 2;   // Booth rows, addend C, negation carry-ins
    localparam int N_LEVELS = 6;          // 18 -> 12 -> 8 -> 6 -> 4 -> 3 -> 2

    function automatic int level_rows(input int lvl);
        int n;
        n = N_ROWS;
        for (int l = 0; l < lvl; l++) n = (n / 3) * 2 + (n % 3);
        return n;
    endfunction

    logic [31:0] ra, rb;
    logic [31:0] neg_bits;
    logic [31:0] tree [N_LEVELS+1][N_ROWS];

    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ra <= '0;
            rb <= '0;
        end else begin
            ra <= A;
            rb <= B;
        end
    end

    for (genvar i = 0; i < N_PP; i++) begin : g_booth
        logic [2:0]  code;
        logic [31:0] mag;
        logic        neg;

        if (i == 0) begin : g_lsb
            assign code = {rb[1:0], 1'b0};
        end else begin : g_mid
            assign code = rb[2*i+1:2*i-1];
        end

        // NOTE: defaults come first so no path through the case leaves a latch behind.
        always_comb begin
            mag = '0;
            neg = 1'b0;
            case (code)
                3'b001, 3'b010: mag = ra;
                3'b011:         mag = {ra[30:0], 1'b0};
                3'b100: begin
                    mag = {ra[30:0], 1'b0};
                    neg = 1'b1;
                end
                3'b101, 3'b110: begin
                    mag = ra;
                    neg = 1'b1;
                end
                default: ;
            endcase
        end

        // Negative rows are inverted here; the +1 lands at bit 2i through neg_bits.
        assign tree[0][i]        = (neg ? ~mag : mag) << (2 * i);
        assign neg_bits[2*i]     = neg;
        assign neg_bits[2*i+1]   = 1'b0;
    end

    assign tree[0][N_PP]     = C;
    assign tree[0][N_PP + 1] = neg_bits;

    for (genvar l = 0; l < N_LEVELS; l++) begin : g_level
        localparam int N_IN  = level_rows(l);
        localparam int N_GRP = N_IN / 3;
        localparam int N_OUT = level_rows(l + 1);

        for (genvar g = 0; g < N_GRP; g++) begin : g_csa
            logic [31:0] x, y, w;
            assign x = tree[l][3*g];
            assign y = tree[l][3*g+1];
            assign w = tree[l][3*g+2];
            assign tree[l+1][2*g]   = x ^ y ^ w;
            assign tree[l+1][2*g+1] = {(x[30:0] & y[30:0]) | (x[30:0] & w[30:0]) |
                                       (y[30:0] & w[30:0]), 1'b0};
        end

        for (genvar p = 0; p < N_IN - 3 * N_GRP; p++) begin : g_pass
            assign tree[l+1][2*N_GRP+p] = tree[l][3*N_GRP+p];
        end

        for (genvar u = N_OUT; u < N_ROWS; u++) begin : g_unused
            assign tree[l+1][u] = '0;
        end
    end

    assign Z = tree[N_LEVELS][0] + tree[N_LEVELS][1];

endmodule

// File: tb/tb_madd.sv
// Self-checking bench for madd. Expected Z values are queued when stimulus is driven,
// and they are popped and compared while the DUT output is stable.
module tb_madd;

    logic        CLK;
    logic        RST_N;
    logic [31:0] A, B, C;
    logic [31:0] Z;

    logic [31:0] sb[$];
    int passed = 0;
    int total  = 0;

    madd dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .A    (A),
        .B    (B),
        .C    (C),
        .Z    (Z)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c);
        logic [63:0] p;
        p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        return p[31:0] + c;
    endfunction

    // Load A/B before an edge, then drive C after it and queue the expected result.
    task automatic drive_vec(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        @(negedge CLK);
        A = a;
        B = b;
        @(posedge CLK);
        #1;
        C = c;
        sb.push_back(model(a, b, c));
    endtask

    task automatic test_reset;
        logic [31:0] exp;
        RST_N = 1'b0;
        A = 32'hDEAD_BEEF;
        B = 32'h1234_5677;
        C = 32'h1234_5678;
        #2;
        sb.push_back(32'h1234_5678);
        exp = sb.pop_front();
        total++;
        if (Z !== exp) $display("FAIL reset_z_eq_c: got %h expected %h", Z, exp);
        else passed++;
        @(posedge CLK);
        #1;
        sb.push_back(32'h1234_5678);
        exp = sb.pop_front();
        total++;
        if (Z !== exp) $display("FAIL reset_held_over_edge: got %h expected %h", Z, exp);
        else passed++;
        @(negedge CLK);
        RST_N = 1'b1;
        A = 32'd3;
        B = 32'd5;
        @(posedge CLK);
        #1;
        C = 32'd7;
        sb.push_back(32'h0000_0016);
        #1;
        exp = sb.pop_front();
        total++;
        if (Z !== exp) $display("FAIL reset_first_vec: got %h expected %h", Z, exp);
        else passed++;
    endtask

    task automatic test_signs;
        logic [31:0] exp;
        drive_vec(32'hFFFF_FFFF, 32'd1, 32'd0);
        #1;
        exp = sb.pop_front();
        total++;
        if (Z !== exp || Z !== 32'hFFFF_FFFF) $display("FAIL signs_neg1x1: got %h expected %h", Z, exp);
        else passed++;
        drive_vec(-32'sd7, -32'sd6, -32'sd42);
        #1;
        exp = sb.pop_front();
        total++;
        if (Z !== exp || Z !== 32'h0) $display("FAIL signs_m7xm6: got %h expected %h", Z, exp);
        else passed++;
        // Z must follow a mid-cycle change of C with the same registered operands.
        C = 32'h0000_1000;
        sb.push_back(32'h0000_102A);
        #1;
        exp = sb.pop_front();
        total++;
        if (Z !== exp) $display("FAIL signs_c_tracks: got %h expected %h", Z, exp);
        else passed++;
    endtask

    task automatic test_extremes;
        logic [31:0] exp;
        drive_vec(32'h8000_0000, 32'h8000_0000, 32'd0);
        #1;
        exp = sb.pop_front();
        total++;
        if (Z !== exp || Z !== 32'h0) $display("FAIL extreme_min_sq: got %h expected %h", Z, exp);
        else passed++;
        drive_vec(32'h7FFF_FFFF, 32'd2, 32'd1);
        #1;
        exp = sb.pop_front();
        total++;
        if (Z !== exp || Z !== 32'hFFFF_FFFF) $display("FAIL extreme_max_x2: got %h expected %h", Z, exp);
        else passed++;
        drive_vec(32'h8000_0000, 32'h0000_0003, 32'h0000_0005);
        #1;
        exp = sb.pop_front();
        total++;
        if (Z !== exp) $display("FAIL extreme_min_x3: got %h expected %h", Z, exp);
        else passed++;
        drive_vec(32'h1234_5679, 32'h8000_0000, 32'hFFFF_FFFF);
        #1;
        exp = sb.pop_front();
        total++;
        if (Z !== exp) $display("FAIL extreme_b_min: got %h expected %h", Z, exp);
        else passed++;
    endtask

    task automatic test_booth_codes;
        logic [31:0] exp;
        logic [31:0] bvals [4];
        bvals[0] = 32'hAAAA_AAAA;
        bvals[1] = 32'h5555_5555;
        bvals[2] = 32'hFFFF_FFFF;
        bvals[3] = 32'h6DB6_DB6D;
        for (int k = 0; k < 4; k++) begin
            drive_vec(32'h1234_5678, bvals[k], 32'd0);
            #1;
            exp = sb.pop_front();
            total++;
            if (Z !== exp) $display("FAIL booth_b_%h: got %h expected %h", bvals[k], Z, exp);
            else passed++;
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp;
        logic [31:0] va [129];
        logic [31:0] vb [129];
        logic [31:0] vc [129];
        int errs;
        errs = 0;
        for (int k = 0; k < 129; k++) begin
            va[k] = $urandom;
            vb[k] = $urandom;
            vc[k] = $urandom;
        end
        @(negedge CLK);
        A = va[0];
        B = vb[0];
        for (int k = 0; k < 128; k++) begin
            @(posedge CLK);
            #1;
            C = vc[k];
            A = va[k+1];
            B = vb[k+1];
            sb.push_back(model(va[k], vb[k], vc[k]));
            #1;
            exp = sb.pop_front();
            total++;
            if (Z !== exp) begin
                if (errs < 8) $display("FAIL b2b_vec%0d: got %h expected %h", k, Z, exp);
                errs++;
            end else passed++;
        end
    endtask

    task automatic test_async_reset;
        logic [31:0] exp;
        drive_vec(32'h1111_1111, 32'd3, 32'd5);
        #1;
        exp = sb.pop_front();
        total++;
        if (Z !== exp) $display("FAIL async_pre: got %h expected %h", Z, exp);
        else passed++;
        C = 32'hCAFE_F00D;
        RST_N = 1'b0;
        sb.push_back(32'hCAFE_F00D);
        #1;
        exp = sb.pop_front();
        total++;
        if (Z !== exp) $display("FAIL async_drop: got %h expected %h", Z, exp);
        else passed++;
        RST_N = 1'b1;
        A = 32'hFFFF_FFF0;
        B = 32'h0000_0101;
        @(posedge CLK);
        #1;
        C = 32'h0000_0123;
        sb.push_back(model(32'hFFFF_FFF0, 32'h0000_0101, 32'h0000_0123));
        #1;
        exp = sb.pop_front();
        total++;
        if (Z !== exp) $display("FAIL async_next_vec: got %h expected %h", Z, exp);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_signs();
        test_extremes();
        test_booth_codes();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
